cmd_port_hub: RTL and testbench

CMD_PORT_HUB -- requirements
Module: cmd_port_hub

---
 rtl/cmd_port_hub.sv | 144 ++++++++++++++
 tb/tb_cmd_port_hub.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cmd_port_hub.sv
// cmd_port_hub: processor port hub with output registers, input channels and an interrupt controller.
// Optional interrupt logic is built only when CMD_HUB_IRQ_EN is defined.
`default_nettype none

module cmd_port_hub #(
   parameter int         NUM_OUT   = 4,
   parameter int         NUM_IN    = 4,
   parameter int         NUM_IRQ   = 4,
   parameter logic [7:0] BASE_ADDR = 8'h00
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           port_id,
   input  logic [7:0]           port_out,
   input  logic                 write_strobe,
   input  logic                 kwrite_strobe,
   input  logic                 read_strobe,
   output logic [7:0]           port_in,
   output logic                 interrupt,
   input  logic                 interrupt_ack,
   output logic [NUM_OUT*8-1:0] out_data,
   output logic [NUM_OUT-1:0]   out_wr,
   input  logic [NUM_IN*8-1:0]  in_data,
   output logic [NUM_IN-1:0]    in_rd,
   input  logic [NUM_IRQ-1:0]   irq_src
);

   logic [7:0] off;
   logic       in_win;

   logic [NUM_OUT-1:0][7:0] out_q, out_d;
   logic [NUM_OUT-1:0]      wr_q, wr_d;
   logic [NUM_IN-1:0]       rd_q, rd_d;
   logic [7:0]              pin_q, pin_d;

   // The window is 32 ports above BASE_ADDR; wrap-around below the base falls outside it.
   assign off    = port_id - BASE_ADDR;
   assign in_win = (off[7:5] == 3'b000);

`ifdef CMD_HUB_IRQ_EN
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ASSERT  = 2'd1,
      S_SERVICE = 2'd2
   } irq_state_t;

   irq_state_t         state_q, state_d;
   logic [NUM_IRQ-1:0] pend_q, pend_d, mask_q, mask_d, hist_q, rise, clr;
   logic               armed_q, clr_wr;

   assign clr_wr = write_strobe && (off == 8'h1A);
   assign clr    = clr_wr ? port_out[NUM_IRQ-1:0] : '0;
   assign rise   = armed_q ? (irq_src & ~hist_q) : '0;
   assign pend_d = (pend_q & ~clr) | rise;
   assign mask_d = (write_strobe && (off == 8'h19)) ? port_out[NUM_IRQ-1:0] : mask_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if ((pend_q & mask_q) != '0) state_d = S_ASSERT;
         S_ASSERT:  if (interrupt_ack) state_d = S_SERVICE;
         S_SERVICE: if (clr_wr) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // History is armed one cycle after reset so a source held high through reset is not seen as an edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         pend_q  <= '0;
         mask_q  <= '0;
         hist_q  <= '0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         mask_q  <= mask_d;
         hist_q  <= irq_src;
         armed_q <= 1'b1;
      end
   end

   assign interrupt = (state_q == S_ASSERT);
`else
   logic unused_irq;
   assign unused_irq = &{1'b0, irq_src, interrupt_ack};
   assign interrupt  = 1'b0;
`endif

   always_comb begin
      out_d = out_q;
      wr_d  = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
         if (write_strobe && in_win && !off[4] && (off[3:0] == 4'(i))) begin
            out_d[i] = port_out;
            wr_d[i]  = 1'b1;
         end else if (kwrite_strobe && (port_id[3:0] == 4'(i))) begin
            out_d[i] = port_out;
            wr_d[i]  = 1'b1;
         end
      end
   end

   always_comb begin
      rd_d  = '0;
      pin_d = 8'h00;
      for (int i = 0; i < NUM_OUT; i++) begin
         if (in_win && !off[4] && (off[3:0] == 4'(i))) pin_d = out_q[i];
      end
      for (int j = 0; j < NUM_IN; j++) begin
         if (in_win && (off[4:3] == 2'b10) && (off[2:0] == 3'(j))) begin
            pin_d   = in_data[8*j +: 8];
            rd_d[j] = read_strobe;
         end
      end
`ifdef CMD_HUB_IRQ_EN
      if (off == 8'h18) pin_d = 8'(pend_q);
      if (off == 8'h19) pin_d = 8'(mask_q);
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_q <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         pin_q <= 8'h00;
      end else begin
         out_q <= out_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         pin_q <= pin_d;
      end
   end

   assign out_data = out_q;
   assign out_wr   = wr_q;
   assign in_rd    = rd_q;
   assign port_in  = pin_q;

endmodule

`default_nettype wire

// File: tb/tb_cmd_port_hub.sv
// Testbench for cmd_port_hub: table-driven port accesses plus interrupt and reset sequences.
`default_nettype none

module tb_cmd_port_hub;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  port_id, port_out, port_in;
   logic        write_strobe, kwrite_strobe, read_strobe;
   logic        interrupt, interrupt_ack;
   logic [31:0] out_data;
   logic [3:0]  out_wr, in_rd, irq_src;
   logic [31:0] in_data;

   int checks = 0;
   int errors = 0;

   cmd_port_hub #(
      .NUM_OUT(4), .NUM_IN(4), .NUM_IRQ(4), .BASE_ADDR(8'h40)
   ) dut (
      .clk(clk), .reset(reset), .port_id(port_id), .port_out(port_out),
      .write_strobe(write_strobe), .kwrite_strobe(kwrite_strobe), .read_strobe(read_strobe),
      .port_in(port_in), .interrupt(interrupt), .interrupt_ack(interrupt_ack),
      .out_data(out_data), .out_wr(out_wr), .in_data(in_data), .in_rd(in_rd),
      .irq_src(irq_src)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ws, kws, rs;
      logic [7:0]  pid, pout;
      logic [31:0] e_out;
      logic [3:0]  e_wr, e_rd;
      logic [7:0]  e_pin;
   } vec_t;

   vec_t tv[18];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setin(input logic ws, input logic kws, input logic rs,
                        input logic [7:0] pid, input logic [7:0] pout);
      write_strobe  = ws;
      kwrite_strobe = kws;
      read_strobe   = rs;
      port_id       = pid;
      port_out      = pout;
   endtask

   initial begin
      logic [7:0] mask_rb;
`ifdef CMD_HUB_IRQ_EN
      mask_rb = 8'h0F;
`else
      mask_rb = 8'h00;
`endif
      tv[0]  = '{1'b1, 1'b0, 1'b0, 8'h42, 8'hA5, 32'h00A5_0000, 4'b0100, 4'b0000, 8'h00};
      tv[1]  = '{1'b0, 1'b0, 1'b0, 8'h42, 8'h00, 32'h00A5_0000, 4'b0000, 4'b0000, 8'hA5};
      tv[2]  = '{1'b0, 1'b1, 1'b0, 8'h91, 8'h3C, 32'h00A5_3C00, 4'b0010, 4'b0000, 8'h00};
      tv[3]  = '{1'b0, 1'b1, 1'b0, 8'h9F, 8'h77, 32'h00A5_3C00, 4'b0000, 4'b0000, 8'h00};
      tv[4]  = '{1'b0, 1'b0, 1'b0, 8'h52, 8'h00, 32'h00A5_3C00, 4'b0000, 4'b0000, 8'h5A};
      tv[5]  = '{1'b0, 1'b0, 1'b1, 8'h52, 8'h00, 32'h00A5_3C00, 4'b0000, 4'b0100, 8'h5A};
      tv[6]  = '{1'b0, 1'b0, 1'b0, 8'h41, 8'h00, 32'h00A5_3C00, 4'b0000, 4'b0000, 8'h3C};
      tv[7]  = '{1'b1, 1'b0, 1'b0, 8'h44, 8'hFF, 32'h00A5_3C00, 4'b0000, 4'b0000, 8'h00};
      tv[8]  = '{1'b1, 1'b0, 1'b0, 8'h02, 8'hFF, 32'h00A5_3C00, 4'b0000, 4'b0000, 8'h00};
      tv[9]  = '{1'b1, 1'b0, 1'b0, 8'h43, 8'hC3, 32'hC3A5_3C00, 4'b1000, 4'b0000, 8'h00};
      tv[10] = '{1'b0, 1'b0, 1'b1, 8'h54, 8'h00, 32'hC3A5_3C00, 4'b0000, 4'b0000, 8'h00};
      tv[11] = '{1'b0, 1'b0, 1'b1, 8'h50, 8'h00, 32'hC3A5_3C00, 4'b0000, 4'b0001, 8'h11};
      tv[12] = '{1'b0, 1'b1, 1'b0, 8'h03, 8'h99, 32'h99A5_3C00, 4'b1000, 4'b0000, 8'h00};
      tv[13] = '{1'b1, 1'b0, 1'b0, 8'h58, 8'hFF, 32'h99A5_3C00, 4'b0000, 4'b0000, 8'h00};
      tv[14] = '{1'b1, 1'b0, 1'b0, 8'h59, 8'h0F, 32'h99A5_3C00, 4'b0000, 4'b0000, 8'h00};
      tv[15] = '{1'b0, 1'b0, 1'b0, 8'h59, 8'h00, 32'h99A5_3C00, 4'b0000, 4'b0000, mask_rb};
      tv[16] = '{1'b1, 1'b0, 1'b0, 8'h5A, 8'h0F, 32'h99A5_3C00, 4'b0000, 4'b0000, 8'h00};
      tv[17] = '{1'b0, 1'b0, 1'b0, 8'h43, 8'h00, 32'h99A5_3C00, 4'b0000, 4'b0000, 8'h99};

      reset = 1'b0;
      interrupt_ack = 1'b0;
      irq_src = 4'h0;
      in_data = 32'h445A_2211;
      setin(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      tick();
      tick();
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_out_wr", {28'h0, out_wr}, 32'h0);
      chk("rst_in_rd", {28'h0, in_rd}, 32'h0);
      chk("rst_port_in", {24'h0, port_in}, 32'h0);
      chk("rst_interrupt", {31'h0, interrupt}, 32'h0);
      reset = 1'b1;

      for (int k = 0; k < 18; k++) begin
         setin(tv[k].ws, tv[k].kws, tv[k].rs, tv[k].pid, tv[k].pout);
         tick();
         chk($sformatf("v%0d_out_data", k), out_data, tv[k].e_out);
         chk($sformatf("v%0d_out_wr", k), {28'h0, out_wr}, {28'h0, tv[k].e_wr});
         chk($sformatf("v%0d_in_rd", k), {28'h0, in_rd}, {28'h0, tv[k].e_rd});
         chk($sformatf("v%0d_port_in", k), {24'h0, port_in}, {24'h0, tv[k].e_pin});
         chk($sformatf("v%0d_interrupt", k), {31'h0, interrupt}, 32'h0);
      end

`ifdef CMD_HUB_IRQ_EN
      setin(1'b1, 1'b0, 1'b0, 8'h59, 8'h01);
      tick();
      irq_src = 4'b0001;
      setin(1'b0, 1'b0, 1'b0, 8'h58, 8'h00);
      tick();
      chk("irq0_not_yet", {31'h0, interrupt}, 32'h0);
      tick();
      chk("irq0_assert", {31'h0, interrupt}, 32'h1);
      chk("irq0_pend_read", {24'h0, port_in}, 32'h01);
      setin(1'b1, 1'b0, 1'b0, 8'h59, 8'h00);
      tick();
      chk("mask_all_hold", {31'h0, interrupt}, 32'h1);
      setin(1'b0, 1'b0, 1'b0, 8'h41, 8'h00);
      interrupt_ack = 1'b1;
      tick();
      interrupt_ack = 1'b0;
      chk("ack_drop", {31'h0, interrupt}, 32'h0);
      tick();
      chk("service_hold", {31'h0, interrupt}, 32'h0);
      setin(1'b1, 1'b0, 1'b0, 8'h5A, 8'h01);
      tick();
      chk("clr_int_low", {31'h0, interrupt}, 32'h0);
      setin(1'b0, 1'b0, 1'b0, 8'h58, 8'h00);
      tick();
      chk("pend_cleared", {24'h0, port_in}, 32'h00);
      tick();
      chk("idle_stays", {31'h0, interrupt}, 32'h0);

      setin(1'b1, 1'b0, 1'b0, 8'h59, 8'h02);
      tick();
      irq_src = 4'b0011;
      setin(1'b0, 1'b0, 1'b0, 8'h58, 8'h00);
      tick();
      tick();
      chk("irq1_assert", {31'h0, interrupt}, 32'h1);
      chk("irq1_pend_read", {24'h0, port_in}, 32'h02);
      interrupt_ack = 1'b1;
      tick();
      interrupt_ack = 1'b0;
      chk("irq1_ack", {31'h0, interrupt}, 32'h0);
      irq_src = 4'b0001;
      tick();
      irq_src = 4'b0011;
      setin(1'b1, 1'b0, 1'b0, 8'h5A, 8'h02);
      tick();
      chk("svc_exit_low", {31'h0, interrupt}, 32'h0);
      setin(1'b0, 1'b0, 1'b0, 8'h58, 8'h00);
      tick();
      chk("set_wins", {24'h0, port_in}, 32'h02);
      chk("reassert", {31'h0, interrupt}, 32'h1);

      setin(1'b0, 1'b0, 1'b0, 8'h41, 8'h00);
      tick();
      chk("pre_rst_int", {31'h0, interrupt}, 32'h1);
      chk("pre_rst_port_in", {24'h0, port_in}, 32'h3C);
      #2 reset = 1'b0;
      #1;
      chk("async_rst_int", {31'h0, interrupt}, 32'h0);
      chk("async_rst_out", out_data, 32'h0);
      chk("async_rst_port_in", {24'h0, port_in}, 32'h0);
      tick();
      reset = 1'b1;
      setin(1'b1, 1'b0, 1'b0, 8'h59, 8'h03);
      tick();
      setin(1'b0, 1'b0, 1'b0, 8'h58, 8'h00);
      tick();
      tick();
      chk("no_spurious_pend", {24'h0, port_in}, 32'h00);
      chk("no_spurious_int", {31'h0, interrupt}, 32'h0);
`else
      setin(1'b0, 1'b0, 1'b0, 8'h41, 8'h00);
      tick();
      chk("pre_rst_port_in", {24'h0, port_in}, 32'h3C);
      #2 reset = 1'b0;
      #1;
      chk("async_rst_out", out_data, 32'h0);
      chk("async_rst_port_in", {24'h0, port_in}, 32'h0);
      tick();
      reset = 1'b1;
      irq_src = 4'hF;
      setin(1'b1, 1'b0, 1'b0, 8'h59, 8'hFF);
      tick();
      irq_src = 4'h0;
      tick();
      irq_src = 4'hF;
      setin(1'b0, 1'b0, 1'b0, 8'h59, 8'h00);
      tick();
      tick();
      chk("noirq_mask_read", {24'h0, port_in}, 32'h00);
      chk("noirq_int_const", {31'h0, interrupt}, 32'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
